// File: rtl/abs_diff_error_sweeper.sv
// abs_diff_error_sweeper
// Exhaustively drives every input vector into a combinational approximate
// |A-B| candidate circuit and scores each response against the exact
// absolute difference. It accumulates the worst-case error, the error sum,
// the count of threshold violations and the first failing vector, and
// finishes with an on-chip pass/fail verdict.
module abs_diff_error_sweeper #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [IN_W-1:0]       cand_in_o,
  input  logic [OUT_W-1:0]      cand_out_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [OUT_W-1:0]      max_err_o,
  output logic [OUT_W+IN_W-1:0] sum_err_o,
  output logic [IN_W:0]         err_count_o,
  output logic [IN_W-1:0]       first_fail_o,
  output logic                  fail_seen_o
);

  localparam int HALF = IN_W / 2;
  localparam logic [OUT_W:0] ET_W = (OUT_W + 1)'(ET);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t state_q, state_d;

  // start is captured one cycle before the sweep begins, so vector v is
  // scored at edge S+2+v and the verdict lands 2^IN_W+1 edges after start
  logic startReq_q, startReq_d;

  logic [IN_W-1:0]       candIn_q, candIn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [OUT_W-1:0]      maxErr_q, maxErr_d;
  logic [OUT_W+IN_W-1:0] sumErr_q, sumErr_d;
  logic [IN_W:0]         errCount_q, errCount_d;
  logic [IN_W-1:0]       firstFail_q, firstFail_d;
  logic                  failSeen_q, failSeen_d;

  logic [HALF-1:0]  opA, opB, diffAB;
  logic [OUT_W:0]   exactExt, candExt, errWide;
  logic [OUT_W-1:0] err;
  logic             violation;
  logic             lastVec;
  logic [IN_W:0]    countNext;

  // Score the vector currently on cand_in against the exact |A-B| reference;
  // the error is formed one bit wider so the subtraction never wraps
  always_comb begin
    opA       = candIn_q[HALF-1:0];
    opB       = candIn_q[IN_W-1:HALF];
    diffAB    = (opA >= opB) ? (opA - opB) : (opB - opA);
    exactExt  = (OUT_W + 1)'(diffAB);
    candExt   = (OUT_W + 1)'(cand_out_i);
    errWide   = (exactExt >= candExt) ? (exactExt - candExt) : (candExt - exactExt);
    err       = errWide[OUT_W-1:0];
    violation = (errWide > ET_W);
    lastVec   = &candIn_q;
    countNext = errCount_q + (IN_W + 1)'(violation);
  end

  // State and start-request registers; reset aborts any sweep in progress
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      startReq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      startReq_q <= startReq_d;
    end
  end

  // Next-state logic: a captured start launches a sweep from IDLE or DONE,
  // and the sweep ends after the all-ones vector has been scored
  always_comb begin
    state_d    = state_q;
    startReq_d = start_i && (state_q != SWEEP);
    case (state_q)
      IDLE, DONE: if (startReq_q) state_d = SWEEP;
      SWEEP:      if (lastVec)    state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Output and statistics next values: clear on launch, accumulate one
  // vector per cycle while sweeping, hold everything otherwise
  always_comb begin
    candIn_d    = candIn_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    maxErr_d    = maxErr_q;
    sumErr_d    = sumErr_q;
    errCount_d  = errCount_q;
    firstFail_d = firstFail_q;
    failSeen_d  = failSeen_q;
    case (state_q)
      IDLE, DONE: begin
        if (startReq_q) begin
          candIn_d    = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          maxErr_d    = '0;
          sumErr_d    = '0;
          errCount_d  = '0;
          firstFail_d = '0;
          failSeen_d  = 1'b0;
        end
      end
      SWEEP: begin
        maxErr_d   = (err > maxErr_q) ? err : maxErr_q;
        sumErr_d   = sumErr_q + (OUT_W + IN_W)'(err);
        errCount_d = countNext;
        if (violation && !failSeen_q) begin
          firstFail_d = candIn_q;
          failSeen_d  = 1'b1;
        end
        if (!lastVec) begin
          candIn_d = candIn_q + 1'b1;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (countNext == '0);
        end
      end
      default: ;
    endcase
  end

  // Registered result outputs, all cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      candIn_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      maxErr_q    <= '0;
      sumErr_q    <= '0;
      errCount_q  <= '0;
      firstFail_q <= '0;
      failSeen_q  <= 1'b0;
    end else begin
      candIn_q    <= candIn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      maxErr_q    <= maxErr_d;
      sumErr_q    <= sumErr_d;
      errCount_q  <= errCount_d;
      firstFail_q <= firstFail_d;
      failSeen_q  <= failSeen_d;
    end
  end

  assign cand_in_o    = candIn_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign max_err_o    = maxErr_q;
  assign sum_err_o    = sumErr_q;
  assign err_count_o  = errCount_q;
  assign first_fail_o = firstFail_q;
  assign fail_seen_o  = failSeen_q;

endmodule

// File: tb/tb_abs_diff_error_sweeper.sv
// tb_abs_diff_error_sweeper
// Directed bench: two sweepers (4-bit and 6-bit inputs) scoring simple
// candidate circuits, with hand-computed statistics as the reference.
module tb_abs_diff_error_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;

  logic [3:0] candIn;
  logic [2:0] candOut;
  logic       busy, done, pass, failSeen;
  logic [2:0] maxErr;
  logic [6:0] sumErr;
  logic [4:0] errCount;
  logic [3:0] firstFail;

  logic [5:0] candIn2;
  logic [2:0] candOut2;
  logic       busy2, done2, pass2, failSeen2;
  logic [2:0] maxErr2;
  logic [8:0] sumErr2;
  logic [6:0] errCount2;
  logic [5:0] firstFail2;

  // 0 = exact |A-B|, 1 = constant zero, 2 = exact with LSB flipped
  int mode;
  int total = 0;
  int bad = 0;

  logic [1:0] candA, candB;
  logic [2:0] candExact;

  abs_diff_error_sweeper #(.IN_W(4), .OUT_W(3), .ET(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cand_in_o(candIn), .cand_out_i(candOut),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .max_err_o(maxErr), .sum_err_o(sumErr), .err_count_o(errCount),
    .first_fail_o(firstFail), .fail_seen_o(failSeen)
  );

  abs_diff_error_sweeper #(.IN_W(6), .OUT_W(3), .ET(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2),
    .cand_in_o(candIn2), .cand_out_i(candOut2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .max_err_o(maxErr2), .sum_err_o(sumErr2), .err_count_o(errCount2),
    .first_fail_o(firstFail2), .fail_seen_o(failSeen2)
  );

  // Candidate circuit for the 4-bit sweeper, selected by mode
  always_comb begin
    candA     = candIn[1:0];
    candB     = candIn[3:2];
    candExact = (candA >= candB) ? 3'(candA - candB) : 3'(candB - candA);
    case (mode)
      0:       candOut = candExact;
      1:       candOut = 3'd0;
      default: candOut = candExact ^ 3'b001;
    endcase
  end

  assign candOut2 = 3'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start on the 4-bit sweeper and follow it to done, optionally
  // re-pulsing start while a given vector is on cand_in
  task automatic applyStimulus(input int repulseAt, output int cycles, output int busyCount);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    busyCount = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busyCount++;
      if (cycles == 1) begin
        checkOutput("launchCandIn", candIn, 0);
        checkOutput("launchSumClr", sumErr, 0);
        checkOutput("launchBusy", busy, 1);
        checkOutput("launchDone", done, 0);
      end
      start = (repulseAt >= 0) && (candIn == 4'(repulseAt)) && busy;
    end while (!done && cycles < 200);
    start = 1'b0;
    checkOutput("sweepLen", cycles, 17);
    checkOutput("busyLen", busyCount, 16);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".candIn"}, candIn, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".pass"}, pass, 0);
    checkOutput({tag, ".maxErr"}, maxErr, 0);
    checkOutput({tag, ".sumErr"}, sumErr, 0);
    checkOutput({tag, ".errCount"}, errCount, 0);
    checkOutput({tag, ".firstFail"}, firstFail, 0);
    checkOutput({tag, ".failSeen"}, failSeen, 0);
  endtask

  task automatic checkExactResult(input string tag);
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".pass"}, pass, 1);
    checkOutput({tag, ".maxErr"}, maxErr, 0);
    checkOutput({tag, ".sumErr"}, sumErr, 0);
    checkOutput({tag, ".errCount"}, errCount, 0);
    checkOutput({tag, ".failSeen"}, failSeen, 0);
  endtask

  task automatic checkZeroCandResult(input string tag);
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".pass"}, pass, 0);
    checkOutput({tag, ".maxErr"}, maxErr, 3);
    checkOutput({tag, ".sumErr"}, sumErr, 20);
    checkOutput({tag, ".errCount"}, errCount, 6);
    checkOutput({tag, ".firstFail"}, firstFail, 2);
    checkOutput({tag, ".failSeen"}, failSeen, 1);
    checkOutput({tag, ".candInHeld"}, candIn, 15);
  endtask

  initial begin
    int cycles, busyCount, waitCnt;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // rst and start together: rst wins and the block stays idle
    @(negedge clk) begin rst = 1'b1; start = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start = 1'b0; end
    repeat (3) @(negedge clk);
    checkOutput("rstStart.busy", busy, 0);
    checkOutput("rstStart.candIn", candIn, 0);
    checkOutput("rstStart.done", done, 0);

    mode = 0;
    applyStimulus(-1, cycles, busyCount);
    checkExactResult("exact");

    mode = 1;
    applyStimulus(-1, cycles, busyCount);
    checkZeroCandResult("zero");

    mode = 2;
    applyStimulus(-1, cycles, busyCount);
    checkOutput("xor.done", done, 1);
    checkOutput("xor.pass", pass, 1);
    checkOutput("xor.maxErr", maxErr, 1);
    checkOutput("xor.sumErr", sumErr, 16);
    checkOutput("xor.errCount", errCount, 0);
    checkOutput("xor.failSeen", failSeen, 0);

    // Reset in the middle of a sweep throws away partial statistics
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    waitCnt = 0;
    while (candIn != 4'd7 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("reachVec7", candIn, 7);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checkAllZero("midRst");
    repeat (3) @(negedge clk);
    checkOutput("midRstIdle.busy", busy, 0);
    checkOutput("midRstIdle.candIn", candIn, 0);
    mode = 0;
    applyStimulus(-1, cycles, busyCount);
    checkExactResult("afterRst");

    // start during a sweep is ignored; start in DONE reruns identically
    mode = 1;
    applyStimulus(5, cycles, busyCount);
    checkZeroCandResult("repulse");
    applyStimulus(-1, cycles, busyCount);
    checkZeroCandResult("rerun");

    // Wider sweeper with a constant-zero candidate
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cycles = 0;
    busyCount = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy2) busyCount++;
    end while (!done2 && cycles < 300);
    checkOutput("wide.sweepLen", cycles, 65);
    checkOutput("wide.busyLen", busyCount, 64);
    checkOutput("wide.maxErr", maxErr2, 7);
    checkOutput("wide.errCount", errCount2, 42);
    checkOutput("wide.sumErr", sumErr2, 168);
    checkOutput("wide.firstFail", firstFail2, 2);
    checkOutput("wide.failSeen", failSeen2, 1);
    checkOutput("wide.pass", pass2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
